four_bank_mem_resp: RTL and testbench
=====================================

// Module: four_bank_mem_resp
// PURPOSE
//  Responder side of the cache-to-memory interface: a four-bank, word-interleaved
//  main-memory model serving the cache controller's fill reads and victim write-backs.
//  Selects a bank from Addr[2:1], tracks per-bank busy time, returns read data at a
//  fixed latency, and stalls requests that target a busy bank.
// PARAMETERS
//  BUSY_CYC   3    cycles a bank stays busy after the cycle in which it accepts a request
//  RD_LAT     2    cycles from read-accept edge to DataOut valid (fixed, not tunable in v1)
//  BANK_AW    13   per-bank word-address width (taken from Addr[15:3])
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active high
//  Addr       in   16  byte address; Addr[2:1]=bank, Addr[15:3]=word in bank, Addr[0] must be 0
//  DataIn     in   16  write data
//  wr         in   1   write request
//  rd         in   1   read request
//  DataOut    out  16  read data; valid only while rd_valid=1, else 16'h0000
//  rd_valid   out  1   one-cycle pulse qualifying DataOut
//  stall      out  1   combinational: request present but target bank busy; request not taken
//  busy       out  4   per-bank busy flags (registered)
//  err        out  1   combinational: rd&wr together, or Addr[0]=1 with rd|wr
// BEHAVIOUR
//  Interface: one clock, synchronous active-high reset. All state updates on posedge clk.
//  Accept: in cycle T, (rd^wr) & ~Addr[0] & ~busy[Addr[2:1]] -> accepted; stall=0.
//  Stall:  (rd|wr) & busy[Addr[2:1]] & ~err -> stall=1, nothing accepted, requester holds.
//  Error:  err=1 -> no access, no busy update, stall=0; err has priority over stall.
//  Busy: per-bank down-counter, loaded BUSY_CYC on accept; busy[b]=(cnt[b]!=0).
//   busy[b]=1 in cycles T+1..T+BUSY_CYC; bank b accepts again at T+BUSY_CYC+1.
//   Different banks accept on consecutive cycles (controller's 4-beat burst never stalls).
//  Write: array word updated at the accept edge (end of cycle T). No write response.
//  Read pipeline: s1 {v,bank,word} captured at end of T; array read registered at end of
//   T+1; DataOut/rd_valid driven in cycle T+RD_LAT (=T+2). Pipeline full every cycle OK.
//  Read-after-write same bank: blocked by busy, so reads always see committed data.
//  Simultaneous: one request per cycle max by construction; read and earlier write to
//   different banks proceed independently.
//  Reset: counters=0, busy=0, pipeline valids=0, DataOut=0, rd_valid=0; err/stall follow
//   inputs combinationally. Reads in flight at reset are discarded (no rd_valid).
//   Array contents are not reset.
//  Width rules: bank index 2 bits, counters $clog2(BUSY_CYC+1) bits, no wrap beyond 0.
// STRUCTURE
//  Shared package/include: NUM_BANKS=4, BANK_SEL bit range [2:1], WORD_SEL [15:3],
//   BUSY_CYC / RD_LAT defaults (shared with cache_controller timing).
//  Sub-module mem_bank: one bank = 2^BANK_AW x 16 array, sync write, registered read
//   (1-cycle), its busy counter; instantiated 4x. Top holds decode, err/stall, s1/s2
//   pipeline and DataOut mux.
// TESTING
//  1. wr Addr=16'h0010 DataIn=16'hBEEF, later rd 16'h0010 -> rd_valid at T+2, DataOut=BEEF.
//  2. Burst rd 0x0100,0x0102,0x0104,0x0106 on consecutive cycles -> stall=0 all; four
//     rd_valid pulses T+2..T+5 in order with the written values.
//  3. rd 0x0200 then rd 0x0208 (same bank 0) next cycle -> stall=1 for cycles T+1..T+3,
//     accepted T+4, data at T+6; busy=4'b0001 during T+1..T+3.
//  4. rd=wr=1 or Addr=0x0011 -> err=1, stall=0, busy unchanged, no rd_valid.
//  5. rst asserted at T+1 after rd accept -> no rd_valid at T+2, busy=0, DataOut=0.
//  6. Write to bank 2 then read bank 2 after busy clears -> new data; bank 3 untouched.

Source files
------------

// File: rtl/four_bank_mem_resp_pkg.sv
// Shared parameters and helpers for the four-bank word-interleaved memory responder.
// Timing values here are also assumed by the cache controller.
package four_bank_mem_resp_pkg;

  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned ADDR_W    = 16;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned BANK_LSB  = 1;
  localparam int unsigned BANK_MSB  = 2;
  localparam int unsigned WORD_LSB  = 3;
  localparam int unsigned WORD_MSB  = 15;
  localparam int unsigned BANK_IW   = BANK_MSB - BANK_LSB + 1;
  localparam int unsigned BANK_AW   = WORD_MSB - WORD_LSB + 1;
  localparam int unsigned BUSY_CYC  = 3;
  localparam int unsigned RD_LAT    = 2;
  localparam int unsigned CNT_W     = $clog2(BUSY_CYC + 1);

  typedef logic [BANK_IW-1:0] bank_idx_t;
  typedef logic [BANK_AW-1:0] word_idx_t;

  typedef struct packed {
    logic      v;
    bank_idx_t bank;
    word_idx_t word;
  } rd_s1_t;

  function automatic bank_idx_t bank_of(input logic [ADDR_W-1:0] a);
    return a[BANK_MSB:BANK_LSB];
  endfunction

  function automatic word_idx_t word_of(input logic [ADDR_W-1:0] a);
    return a[WORD_MSB:WORD_LSB];
  endfunction

endpackage

// File: rtl/four_bank_mem_resp_mem_bank.sv
// One memory bank: synchronous write, one-cycle registered read, and the
// down-counter that keeps the bank busy for BUSY_CYC cycles after an accept.
module four_bank_mem_resp_mem_bank
  import four_bank_mem_resp_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_acc,
  input  logic              i_wr,
  input  word_idx_t         i_wr_word,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_rd_en,
  input  word_idx_t         i_rd_word,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_busy
);

  logic [DATA_W-1:0] r_mem [2**BANK_AW];
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_acc) begin
      r_cnt <= CNT_W'(BUSY_CYC);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // Array contents are deliberately left out of reset.
  always_ff @(posedge i_clk) begin
    if (i_acc && i_wr) begin
      r_mem[i_wr_word] <= i_wdata;
    end
    if (i_rd_en) begin
      r_rdata <= r_mem[i_rd_word];
    end
  end

  assign o_rdata = r_rdata;
  assign o_busy  = (r_cnt != '0);

endmodule

// File: rtl/four_bank_mem_resp.sv
// Four-bank responder top: request decode, err/stall, two-stage read pipeline
// and the read-data mux. Bank storage and busy timing live in mem_bank.
module four_bank_mem_resp
  import four_bank_mem_resp_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data_in,
  input  logic              i_wr,
  input  logic              i_rd,
  output logic [DATA_W-1:0] o_data_out,
  output logic              o_rd_valid,
  output logic              o_stall,
  output logic [NUM_BANKS-1:0] o_busy,
  output logic              o_err
);

  bank_idx_t            w_bank;
  word_idx_t            w_word;
  logic                 w_req;
  logic                 w_err;
  logic                 w_bank_busy;
  logic                 w_accept;
  logic [NUM_BANKS-1:0] w_busy;
  logic [NUM_BANKS-1:0] w_acc;
  logic [NUM_BANKS-1:0] w_rd_en;
  logic [DATA_W-1:0]    w_rdata [NUM_BANKS];

  rd_s1_t    r_s1;
  logic      r_s2_v;
  bank_idx_t r_s2_bank;

  assign w_bank      = bank_of(i_addr);
  assign w_word      = word_of(i_addr);
  assign w_req       = i_rd | i_wr;
  assign w_err       = (i_rd & i_wr) | (i_addr[0] & w_req);
  assign w_bank_busy = w_busy[w_bank];
  // Error outranks stall: a malformed request is never reported as waiting.
  assign w_accept    = (i_rd ^ i_wr) & ~i_addr[0] & ~w_bank_busy & ~i_rst;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign w_acc[b]   = w_accept & (w_bank == bank_idx_t'(b));
    assign w_rd_en[b] = r_s1.v & (r_s1.bank == bank_idx_t'(b));

    four_bank_mem_resp_mem_bank u_bank (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_acc     (w_acc[b]),
      .i_wr      (i_wr),
      .i_wr_word (w_word),
      .i_wdata   (i_data_in),
      .i_rd_en   (w_rd_en[b]),
      .i_rd_word (r_s1.word),
      .o_rdata   (w_rdata[b]),
      .o_busy    (w_busy[b])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1      <= '0;
      r_s2_v    <= 1'b0;
      r_s2_bank <= '0;
    end else begin
      r_s1      <= '{v: w_accept & i_rd, bank: w_bank, word: w_word};
      r_s2_v    <= r_s1.v;
      r_s2_bank <= r_s1.bank;
    end
  end

  assign o_data_out = r_s2_v ? w_rdata[r_s2_bank] : '0;
  assign o_rd_valid = r_s2_v;
  assign o_stall    = w_req & w_bank_busy & ~w_err;
  assign o_busy     = w_busy;
  assign o_err      = w_err;

endmodule

// File: tb/tb_four_bank_mem_resp.sv
// Self-checking bench: flat word-memory reference model with per-bank "busy until"
// times and a queue of due read responses, compared against the DUT each cycle.
module tb_four_bank_mem_resp;
  import four_bank_mem_resp_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [15:0] addr = '0;
  logic [15:0] din = '0;
  logic [15:0] data_out;
  logic        rd_valid;
  logic        stall;
  logic [3:0]  busy;
  logic        err;

  four_bank_mem_resp dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_addr     (addr),
    .i_data_in  (din),
    .i_wr       (wr),
    .i_rd       (rd),
    .o_data_out (data_out),
    .o_rd_valid (rd_valid),
    .o_stall    (stall),
    .o_busy     (busy),
    .o_err      (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct packed {
    logic        rst;
    logic        rd;
    logic        wr;
    logic [15:0] a;
    logic [15:0] d;
  } stim_t;

  typedef struct {
    int          due;
    logic [15:0] data;
    bit          known;
  } rd_exp_t;

  // Reference model: memory is a flat array of words indexed by addr[15:1].
  logic [15:0] ref_mem [32768];
  bit          ref_known [32768];
  int          busy_until [4] = '{-1, -1, -1, -1};
  rd_exp_t     pend [$];
  int          cyc = 0;

  logic        exp_err, exp_stall, exp_rv;
  logic [3:0]  exp_busy;
  logic [15:0] exp_dout;
  bit          exp_known;

  function automatic stim_t mk(input logic r_st, input logic r, input logic w,
                               input logic [15:0] a, input logic [15:0] d);
    return '{rst: r_st, rd: r, wr: w, a: a, d: d};
  endfunction

  task automatic model_eval();
    for (int b = 0; b < 4; b++) exp_busy[b] = (cyc <= busy_until[b]);
    exp_err   = (rd && wr) || (addr[0] && (rd || wr));
    exp_stall = (rd || wr) && exp_busy[addr[2:1]] && !exp_err;
    exp_rv    = 1'b0;
    exp_dout  = 16'h0000;
    exp_known = 1'b1;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rv    = 1'b1;
      exp_dout  = pend[0].data;
      exp_known = pend[0].known;
    end
  endtask

  task automatic model_commit();
    int b;
    b = int'(addr[2:1]);
    if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
    if (rst) begin
      for (int k = 0; k < 4; k++) busy_until[k] = -1;
      pend.delete();
    end else if ((rd ^ wr) && !addr[0] && !(cyc <= busy_until[b])) begin
      busy_until[b] = cyc + int'(BUSY_CYC);
      if (wr) begin
        ref_mem[addr[15:1]]   = din;
        ref_known[addr[15:1]] = 1'b1;
      end else begin
        pend.push_back('{due: cyc + int'(RD_LAT), data: ref_mem[addr[15:1]],
                         known: ref_known[addr[15:1]]});
      end
    end
    cyc++;
  endtask

  task automatic begin_cycle(input stim_t s);
    rst = s.rst; rd = s.rd; wr = s.wr; addr = s.a; din = s.d;
    @(negedge clk);
    model_eval();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic test_reset();
    stim_t seq [$];
    seq.push_back(mk(1, 0, 0, 16'h0000, 16'h0000));
    seq.push_back(mk(1, 1, 1, 16'h0010, 16'h1234));
    seq.push_back(mk(0, 0, 0, 16'h0000, 16'h0000));
    foreach (seq[i]) begin
      begin_cycle(seq[i]);
      n_cmp++; if (busy !== 4'b0000) begin n_fail++; $display("FAIL reset busy[%0d]: got %b want 0000", i, busy); end
      n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset rd_valid[%0d]: got %b want 0", i, rd_valid); end
      n_cmp++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL reset dout[%0d]: got %h want 0000", i, data_out); end
      n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL reset err[%0d]: got %b want %b", i, err, exp_err); end
      n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset stall[%0d]: got %b want 0", i, stall); end
      end_cycle();
    end
  endtask

  task automatic test_write_read();
    stim_t seq [$];
    seq.push_back(mk(0, 0, 1, 16'h0010, 16'hBEEF));
    repeat (3) seq.push_back(mk(0, 0, 0, 16'h0000, 16'h0000));
    seq.push_back(mk(0, 1, 0, 16'h0010, 16'h0000));
    repeat (4) seq.push_back(mk(0, 0, 0, 16'h0000, 16'h0000));
    foreach (seq[i]) begin
      begin_cycle(seq[i]);
      n_cmp++; if (busy !== exp_busy) begin n_fail++; $display("FAIL wr_rd busy[%0d]: got %b want %b", i, busy, exp_busy); end
      n_cmp++; if (stall !== exp_stall) begin n_fail++; $display("FAIL wr_rd stall[%0d]: got %b want %b", i, stall, exp_stall); end
      n_cmp++; if (rd_valid !== (i == 6)) begin n_fail++; $display("FAIL wr_rd rd_valid[%0d]: got %b want %b", i, rd_valid, i == 6); end
      n_cmp++; if (data_out !== ((i == 6) ? 16'hBEEF : 16'h0000)) begin
        n_fail++; $display("FAIL wr_rd dout[%0d]: got %h want %h", i, data_out, (i == 6) ? 16'hBEEF : 16'h0000);
      end
      end_cycle();
    end
  endtask

  task automatic test_burst();
    stim_t seq [$];
    int    n_rv = 0;
    for (int k = 0; k < 4; k++) seq.push_back(mk(0, 0, 1, 16'h0100 + 16'(2 * k), 16'($urandom)));
    repeat (3) seq.push_back(mk(0, 0, 0, 16'h0000, 16'h0000));
    for (int k = 0; k < 4; k++) seq.push_back(mk(0, 1, 0, 16'h0100 + 16'(2 * k), 16'h0000));
    repeat (5) seq.push_back(mk(0, 0, 0, 16'h0000, 16'h0000));
    foreach (seq[i]) begin
      begin_cycle(seq[i]);
      if (rd_valid === 1'b1) n_rv++;
      n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL burst stall[%0d]: got %b want 0", i, stall); end
      n_cmp++; if (busy !== exp_busy) begin n_fail++; $display("FAIL burst busy[%0d]: got %b want %b", i, busy, exp_busy); end
      n_cmp++; if (rd_valid !== exp_rv) begin n_fail++; $display("FAIL burst rd_valid[%0d]: got %b want %b", i, rd_valid, exp_rv); end
      n_cmp++; if (data_out !== exp_dout) begin n_fail++; $display("FAIL burst dout[%0d]: got %h want %h", i, data_out, exp_dout); end
      end_cycle();
    end
    n_cmp++; if (n_rv != 4) begin n_fail++; $display("FAIL burst pulses: got %0d want 4", n_rv); end
  endtask

  task automatic test_same_bank_stall();
    stim_t seq [$];
    int    n_stall = 0;
    seq.push_back(mk(0, 0, 1, 16'h0200, 16'($urandom)));
    repeat (3) seq.push_back(mk(0, 0, 0, 16'h0000, 16'h0000));
    seq.push_back(mk(0, 0, 1, 16'h0208, 16'($urandom)));
    repeat (3) seq.push_back(mk(0, 0, 0, 16'h0000, 16'h0000));
    seq.push_back(mk(0, 1, 0, 16'h0200, 16'h0000));
    repeat (4) seq.push_back(mk(0, 1, 0, 16'h0208, 16'h0000));
    repeat (4) seq.push_back(mk(0, 0, 0, 16'h0000, 16'h0000));
    foreach (seq[i]) begin
      begin_cycle(seq[i]);
      if (i >= 9) begin
        if (stall === 1'b1) n_stall++;
        n_cmp++; if (stall !== (i <= 11)) begin n_fail++; $display("FAIL stall stall[%0d]: got %b want %b", i, stall, i <= 11); end
      end
      if (i >= 9 && i <= 11) begin
        n_cmp++; if (busy !== 4'b0001) begin n_fail++; $display("FAIL stall busy[%0d]: got %b want 0001", i, busy); end
      end
      n_cmp++; if (rd_valid !== exp_rv) begin n_fail++; $display("FAIL stall rd_valid[%0d]: got %b want %b", i, rd_valid, exp_rv); end
      n_cmp++; if (data_out !== exp_dout) begin n_fail++; $display("FAIL stall dout[%0d]: got %h want %h", i, data_out, exp_dout); end
      end_cycle();
    end
    n_cmp++; if (n_stall != 3) begin n_fail++; $display("FAIL stall count: got %0d want 3", n_stall); end
  endtask

  task automatic test_err();
    stim_t seq [$];
    seq.push_back(mk(0, 1, 0, 16'h0100, 16'h0000));
    seq.push_back(mk(0, 1, 1, 16'h0100, 16'h5555));
    seq.push_back(mk(0, 1, 0, 16'h0011, 16'h0000));
    seq.push_back(mk(0, 0, 1, 16'h0011, 16'hAAAA));
    seq.push_back(mk(0, 0, 0, 16'h0011, 16'h0000));
    repeat (3) seq.push_back(mk(0, 0, 0, 16'h0000, 16'h0000));
    foreach (seq[i]) begin
      begin_cycle(seq[i]);
      n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL err err[%0d]: got %b want %b", i, err, exp_err); end
      n_cmp++; if (stall !== exp_stall) begin n_fail++; $display("FAIL err stall[%0d]: got %b want %b", i, stall, exp_stall); end
      n_cmp++; if (busy !== exp_busy) begin n_fail++; $display("FAIL err busy[%0d]: got %b want %b", i, busy, exp_busy); end
      n_cmp++; if (rd_valid !== exp_rv) begin n_fail++; $display("FAIL err rd_valid[%0d]: got %b want %b", i, rd_valid, exp_rv); end
      end_cycle();
    end
  endtask

  task automatic test_reset_inflight();
    stim_t seq [$];
    seq.push_back(mk(0, 1, 0, 16'h0010, 16'h0000));
    seq.push_back(mk(1, 0, 0, 16'h0000, 16'h0000));
    repeat (4) seq.push_back(mk(0, 0, 0, 16'h0000, 16'h0000));
    foreach (seq[i]) begin
      begin_cycle(seq[i]);
      n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fly rd_valid[%0d]: got %b want 0", i, rd_valid); end
      n_cmp++; if (data_out !== 16'h0000) begin n_fail++; $display("FAIL rst_fly dout[%0d]: got %h want 0000", i, data_out); end
      n_cmp++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rst_fly busy[%0d]: got %b want %b", i, busy, exp_busy); end
      if (i == 2) begin
        n_cmp++; if (busy !== 4'b0000) begin n_fail++; $display("FAIL rst_fly busy_clr: got %b want 0000", busy); end
      end
      end_cycle();
    end
  endtask

  task automatic test_bank_isolation();
    stim_t       seq [$];
    logic [15:0] v3, v2;
    v3 = 16'($urandom); v2 = ~v3;
    seq.push_back(mk(0, 0, 1, 16'h0016, v3));
    seq.push_back(mk(0, 0, 1, 16'h0014, v2));
    repeat (3) seq.push_back(mk(0, 0, 0, 16'h0000, 16'h0000));
    seq.push_back(mk(0, 1, 0, 16'h0014, 16'h0000));
    seq.push_back(mk(0, 1, 0, 16'h0016, 16'h0000));
    repeat (3) seq.push_back(mk(0, 0, 0, 16'h0000, 16'h0000));
    foreach (seq[i]) begin
      begin_cycle(seq[i]);
      n_cmp++; if (rd_valid !== exp_rv) begin n_fail++; $display("FAIL iso rd_valid[%0d]: got %b want %b", i, rd_valid, exp_rv); end
      if (i == 7) begin
        n_cmp++; if (data_out !== v2) begin n_fail++; $display("FAIL iso bank2: got %h want %h", data_out, v2); end
      end
      if (i == 8) begin
        n_cmp++; if (data_out !== v3) begin n_fail++; $display("FAIL iso bank3: got %h want %h", data_out, v3); end
      end
      end_cycle();
    end
  endtask

  task automatic test_random();
    stim_t cur;
    bit    hold = 1'b0;
    cur = mk(0, 0, 0, 16'h0000, 16'h0000);
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        int sel;
        sel = int'($urandom_range(0, 19));
        cur.a = 16'h0300 + 16'(2 * $urandom_range(0, 15));
        cur.d = 16'($urandom);
        cur.rd = (sel >= 2 && sel < 11) || sel == 19;
        cur.wr = (sel >= 11);
        if (sel == 1) cur.a[0] = 1'b1;
        if (sel == 1) cur.rd = 1'b1;
        if (sel == 0) begin cur.rd = 1'b0; cur.wr = 1'b0; end
      end
      begin_cycle(cur);
      hold = exp_stall;
      n_cmp++; if (err !== exp_err) begin n_fail++; $display("FAIL rand err[%0d]: got %b want %b", i, err, exp_err); end
      n_cmp++; if (stall !== exp_stall) begin n_fail++; $display("FAIL rand stall[%0d]: got %b want %b", i, stall, exp_stall); end
      n_cmp++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rand busy[%0d]: got %b want %b", i, busy, exp_busy); end
      n_cmp++; if (rd_valid !== exp_rv) begin n_fail++; $display("FAIL rand rd_valid[%0d]: got %b want %b", i, rd_valid, exp_rv); end
      if (exp_known) begin
        n_cmp++; if (data_out !== exp_dout) begin n_fail++; $display("FAIL rand dout[%0d]: got %h want %h", i, data_out, exp_dout); end
      end
      end_cycle();
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_write_read();
    test_burst();
    test_same_bank_stall();
    test_err();
    test_reset_inflight();
    test_bank_isolation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
